// File: rtl/cla_wide_seq_if.sv
// Bus between the wide-add requester, the sequencer, and the registered 32-bit CLA stage.
// The sequencer takes the slave view; the requester/CLA side takes the master view.
interface cla_wide_seq_if #(
    parameter int NWORDS = 4
) ();
    logic                   start;
    logic [32*NWORDS-1:0]   op_a;
    logic [32*NWORDS-1:0]   op_b;
    logic                   cin;
    logic [31:0]            add_a;
    logic [31:0]            add_b;
    logic                   add_ci;
    logic [31:0]            add_s;
    logic                   add_co;
    logic                   busy;
    logic                   done;
    logic [32*NWORDS-1:0]   result;
    logic                   cout;

    modport slave (
        input  start, op_a, op_b, cin, add_s, add_co,
        output add_a, add_b, add_ci, busy, done, result, cout
    );

    modport master (
        output start, op_a, op_b, cin, add_s, add_co,
        input  add_a, add_b, add_ci, busy, done, result, cout
    );
endinterface

// File: rtl/cla_wide_seq.sv
// Multi-word add sequencer: feeds a registered 32-bit CLA stage one word at a
// time (LSW first), chains the carry, and assembles the wide sum.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; adder inputs forced to 0
// ISSUE | word idx driven to the CLA stage; it captures at the next edge
// WAIT  | CLA stage registers sum/carry at the next edge
// CAPT  | add_s/add_co valid; stored at the edge, advance or finish
// DONE  | one-cycle done pulse, result/cout valid
module cla_wide_seq #(
    parameter int NWORDS = 4,
    parameter int IW     = 4
) (
    input  logic           clk,
    input  logic           reset,
    cla_wide_seq_if.slave  bus
);
    localparam int W = 32 * NWORDS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_result;
    logic            r_cout;

    logic            w_last;
    logic            w_busy;
    logic            w_done;
    logic [31:0]     w_add_a;
    logic [31:0]     w_add_b;
    logic            w_add_ci;

    assign w_last = (r_idx == IW'(NWORDS - 1));

    // State register; reset abandons any add in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed three-edge walk per word, start only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_CAPT;
            S_CAPT:  w_next_state = w_last ? S_DONE : S_ISSUE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch operands at acceptance, store each returned word in CAPT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op_a  <= bus.op_a;
                        r_op_b  <= bus.op_b;
                        r_idx   <= '0;
                        r_carry <= bus.cin;
                    end
                end
                S_CAPT: begin
                    r_result[32*int'(r_idx) +: 32] <= bus.add_s;
                    r_carry <= bus.add_co;
                    if (w_last) begin
                        r_cout <= bus.add_co;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only, so the adder inputs hold
    // steady for the whole ISSUE/WAIT/CAPT span of a word.
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_add_a  = '0;
        w_add_b  = '0;
        w_add_ci = 1'b0;
        case (r_state)
            S_ISSUE, S_WAIT, S_CAPT: begin
                w_busy   = 1'b1;
                w_add_a  = r_op_a[32*int'(r_idx) +: 32];
                w_add_b  = r_op_b[32*int'(r_idx) +: 32];
                w_add_ci = r_carry;
            end
            S_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.add_a  = w_add_a;
    assign bus.add_b  = w_add_b;
    assign bus.add_ci = w_add_ci;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
endmodule

// File: doc/cla_wide_seq.md
Name: cla_wide_seq

Overview:
- Multi-word add controller that sits directly upstream of the team's registered 32-bit CLA stage.
- That stage has two-edge latency: inputs are registered, then the sum/carry are registered.
- This block splits a wide operand pair into 32-bit words and issues them LSW first to the CLA stage, chaining carry word to word.
- It collects the returned sums into a wide result and signals completion with a one-cycle done pulse.

Parameters:
- NWORDS, 4, number of 32-bit words per operand (operand width = 32*NWORDS). Legal range 2..16.
- IW, 4, width of word index counter; must satisfy 2^IW >= NWORDS.

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new wide add; sampled only in IDLE
- op_a  input  32*NWORDS  operand A
- op_b  input  32*NWORDS  operand B
- cin  input  1  carry into word 0
- add_a  output  32  word of A driven to CLA stage a input
- add_b  output  32  word of B driven to CLA stage b input
- add_ci  output  1  carry driven to CLA stage ci input
- add_s  input  32  registered sum returned by CLA stage
- add_co  input  1  registered carry-out returned by CLA stage
- busy  output  1  high while an add is in progress (ISSUE/WAIT/CAPT)
- done  output  1  one-cycle pulse, result valid
- result  output  32*NWORDS  wide sum, held until next accepted start
- cout  output  1  carry-out of most significant word, held with result

Behaviour:
- Reset (async, immediate) sets:
  - state=IDLE; idx=0; carry reg=0.
  - Operand regs = 0; result=0; cout=0; busy=0; done=0.
  - add_a=0, add_b=0, add_ci=0.
- Reset mid-operation abandons the add. No partial result is kept.
- The CLA stage has no reset. Stale adder contents are harmless because add_s/add_co are sampled only in CAPT.
- add_a, add_b and add_ci are decoded from registered state only (word idx of the operand regs, and the carry reg), with no combinational path from start/op_a/op_b/cin. They are stable for the full ISSUE/WAIT/CAPT span of a word.
- In IDLE and DONE, add_a/add_b/add_ci are 0.
- FSM states and transitions:
  - IDLE: start=1 at edge -> latch op_a, op_b, cin into regs; idx=0; carry=cin; go ISSUE. start=0 -> stay.
  - ISSUE: drive word idx. Next edge the CLA stage captures its inputs -> WAIT.
  - WAIT: next edge the CLA stage registers sum/carry -> CAPT.
  - CAPT: add_s/add_co valid. At the edge, write add_s into result bits [32*idx+31 : 32*idx] and set carry=add_co.
    - If idx==NWORDS-1: cout=add_co, go DONE.
    - Else: idx=idx+1, go ISSUE.
  - DONE: done=1 for exactly this cycle; busy=0 -> IDLE at next edge.
- Latency: an add accepted at edge 0 completes with done high during the cycle following edge 3*NWORDS (12 cycles for NWORDS=4). Throughput is one add per 3*NWORDS+2 cycles.
- start while busy or in DONE is ignored; operands latched at acceptance are unaffected by later input changes.
- result is updated word by word during the add; it is defined as valid only when done=1, and remains stable from DONE until the next accepted start.
- Carry chains through all words. The all-ones + 1 case must ripple to cout.
- Arithmetic is unsigned modulo 2^(32*NWORDS), with overflow reported only via cout.

Test Plan:
- NWORDS=4, op_a=1, op_b=2, cin=0 -> done exactly 12 cycles after acceptance; result=3, cout=0.
- op_a=all ones (128'hFFFF...FFFF), op_b=1, cin=0 -> result=0, cout=1. add_ci observed as 0,1,1,1 for words 0..3.
- op_a=all ones, op_b=0, cin=1 -> result=0, cout=1. op_a=32'hFFFFFFFF in word 0 only, op_b=0, cin=1 -> result word1=1, others 0, cout=0.
- start held high continuously, with operands changed mid-add -> first add's result unchanged. The next add is accepted only after DONE->IDLE, and done pulses once per add.
- Reset asserted during WAIT of word 2 -> all outputs 0 immediately, FSM IDLE. A fresh add 5+7 afterwards gives result=12, with no corruption from stale CLA pipeline contents.
- Random operands (1000 pairs, random cin) compared against {cout,result} = op_a+op_b+cin. busy=1 exactly for the 3*NWORDS cycles of each add.
